pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central control block for the five-stage pipeline. It consumes the load-use `stall` from the hazard detector, the EX-stage branch redirect, the MEM-stage data-memory busy signal, the fetch valid and the halt request. It owns the PC register and drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `REG_WIDTH`, 64, PC and target width
- `RESET_PC`, 0, PC value loaded on reset
- `CNT_WIDTH`, 32, width of the performance counters
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: load-use hazard from the hazard detector.
- `branch_taken` in 1: EX-stage taken branch or jump.
- `branch_target` in REG_WIDTH: redirect PC, used unmodified.
- `dmem_busy` in 1: MEM stage has not completed its access.
- `imem_valid` in 1: fetch data at `pc` is valid this cycle.
- `halt_req` in 1: ecall/ebreak retired in WB.
- `pc` out REG_WIDTH: registered fetch PC.
- `pc_we` out 1: PC advances this cycle.
- `if_id_we` out 1: IF/ID captures.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_ex_bubble` out 1: ID/EX loads a NOP.
- `ex_mem_we` out 1: EX/MEM captures.
- `mem_wb_bubble` out 1: MEM/WB loads a NOP.
- `halted` out 1: the FSM is in HALTED.
- `stall_cycles` out CNT_WIDTH: count of load-use stall cycles.
- `flush_count` out CNT_WIDTH: count of redirects.

## Operation
- FSM states: BOOT, RUN, FREEZE, HALTED. Reset enters BOOT.
- BOOT lasts one cycle and always moves to RUN.
  - `pc_we`=0, `if_id_we`=0, `if_id_flush`=1, `id_ex_bubble`=1.
  - `ex_mem_we`=1, `mem_wb_bubble`=1.
- In RUN and FREEZE, controls are resolved in priority order (highest first):
  1. `halt_req`: go to HALTED. This cycle: `pc_we`=0, `if_id_flush`=1, `id_ex_bubble`=1, `ex_mem_we`=1. WB completes the halting instruction.
  2. `dmem_busy`: state FREEZE. `pc_we`=0, `if_id_we`=0, `ex_mem_we`=0, `id_ex_bubble`=0, `if_id_flush`=0, `mem_wb_bubble`=1. All upstream registers hold.
  3. `branch_taken`: `pc`<=`branch_target`, `pc_we`=1, `if_id_flush`=1, `id_ex_bubble`=1. `flush_count`++.
  4. `stall`: `pc_we`=0, `if_id_we`=0, `id_ex_bubble`=1. `stall_cycles`++.
  5. `!imem_valid`: `pc_we`=0, `if_id_flush`=1.
  6. Otherwise: `pc`<=`pc`+4, `pc_we`=1, `if_id_we`=1, everything else idle (`ex_mem_we`=1).
- FREEZE returns to RUN in the first cycle `dmem_busy` is low. Lower-priority events are evaluated in that same cycle.
- A `branch_taken` or `stall` present during FREEZE is ignored. EX and ID hold, so the signal re-presents after the freeze ends. It is counted only when it is applied.
- HALTED is left only by reset. In HALTED: `pc` held, `pc_we`=0, `if_id_flush`=1, `id_ex_bubble`=1, `mem_wb_bubble`=1, `halted`=1.
- PC arithmetic is modulo 2^REG_WIDTH. `pc`+4 wraps through zero without error.
- Both counters saturate at all-ones and never wrap.

## Timing
- `pc`, the FSM state and both counters are registered.
- All enable, bubble and flush outputs are combinational from the current state and inputs (Mealy). Zero-cycle latency from `stall`, `dmem_busy` or `branch_taken` to the control outputs.
- A redirect is visible on `pc` one cycle after `branch_taken` is sampled.
- While `rst_n`=0 (asynchronously):
  - `pc`=RESET_PC, counters=0, `halted`=0.
  - `pc_we`=0, `if_id_we`=0, `ex_mem_we`=0.
  - `if_id_flush`=1, `id_ex_bubble`=1, `mem_wb_bubble`=1.
- Reset asserted mid-FREEZE or mid-redirect discards the pending event. No state survives reset.

## Structure
- Shared package `pipe_pkg`: the `ctrl_state_t` enum (BOOT, RUN, FREEZE, HALTED), the `INSN_BYTES`=4 constant and the `NOP` encoding (32'h00000013).
- Sub-module `sat_counter` (parameter WIDTH, ports inc/count), instantiated twice.

## Test plan
- Reset release with RESET_PC=0x1000 → BOOT cycle with `pc_we`=0 and flushes asserted, then `pc` steps 0x1000, 0x1004, 0x1008.
- `stall` high for one cycle at `pc`=0x1008 → `pc` holds 0x1008 for one cycle, `id_ex_bubble`=1, `stall_cycles`=1.
- `branch_taken` with target 0x2000 → next `pc`=0x2000, `if_id_flush`=1 and `id_ex_bubble`=1 in the same cycle, `flush_count`=1.
- `dmem_busy` high for 3 cycles with `stall` and `branch_taken` also high → `pc` frozen for 3 cycles, `mem_wb_bubble`=1, counters unchanged. On release, the branch is applied and `flush_count`=1.
- `pc`=2^64−4 with normal flow → next `pc`=0. Force `stall_cycles` to all-ones, then stall → it stays at all-ones.
- `halt_req` → `halted`=1 and `pc` frozen for 10 cycles despite `branch_taken`. `rst_n` pulse → `pc`=RESET_PC, FSM back in BOOT.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline control slice.
package pipe_pkg;

    // Top-level control FSM states.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2,
        HALTED = 2'd3
    } ctrl_state_t;

    // Every instruction is one 32-bit word, so sequential fetch steps by 4 bytes.
    localparam int unsigned INSN_BYTES = 4;

    // Canonical NOP (addi x0, x0, 0) loaded into flushed/bubbled registers.
    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance debug.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Step by one on inc, but stick at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline control: owns the PC, resolves stall/redirect/freeze/halt
// into per-register enable, bubble and flush controls, and counts events.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned          REG_WIDTH = 64,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [REG_WIDTH-1:0] branch_target,
    input  logic                 dmem_busy,
    input  logic                 imem_valid,
    input  logic                 halt_req,
    output logic [REG_WIDTH-1:0] pc,
    output logic                 pc_we,
    output logic                 if_id_we,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_we,
    output logic                 mem_wb_bubble,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    ctrl_state_t          state_q;
    ctrl_state_t          state_d;
    logic [REG_WIDTH-1:0] pc_q;
    logic [REG_WIDTH-1:0] pc_d;
    logic                 stallInc;
    logic                 flushInc;

    // Mealy control resolution; in RUN/FREEZE the if/else chain is the priority order.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_we     = 1'b1;
        mem_wb_bubble = 1'b0;
        stallInc      = 1'b0;
        flushInc      = 1'b0;
        case (state_q)
            BOOT: begin
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                mem_wb_bubble = 1'b1;
                state_d       = RUN;
            end
            RUN, FREEZE: begin
                state_d = RUN;
                if (halt_req) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = HALTED;
                end else if (dmem_busy) begin
                    ex_mem_we     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    state_d       = FREEZE;
                end else if (branch_taken) begin
                    pc_d         = branch_target;
                    pc_we        = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    flushInc     = 1'b1;
                end else if (stall) begin
                    id_ex_bubble = 1'b1;
                    stallInc     = 1'b1;
                end else if (!imem_valid) begin
                    if_id_flush = 1'b1;
                end else begin
                    pc_d     = pc_q + REG_WIDTH'(INSN_BYTES);
                    pc_we    = 1'b1;
                    if_id_we = 1'b1;
                end
            end
            HALTED: begin
                ex_mem_we     = 1'b0;
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        // Reset must quiesce the pipeline immediately, not a cycle later.
        if (!rst_n) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            ex_mem_we     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            stallInc      = 1'b0;
            flushInc      = 1'b0;
        end
    end

    // State and PC registers; reset discards any pending freeze or redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallInc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flushInc),
        .count (flush_count)
    );

    assign pc     = pc_q;
    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

    localparam int unsigned REG_WIDTH = 64;
    localparam logic [63:0] RESET_PC  = 64'h1000;
    localparam int unsigned CNT_WIDTH = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 stall;
    logic                 branch_taken;
    logic [REG_WIDTH-1:0] branch_target;
    logic                 dmem_busy;
    logic                 imem_valid;
    logic                 halt_req;
    logic [REG_WIDTH-1:0] pc;
    logic                 pc_we;
    logic                 if_id_we;
    logic                 if_id_flush;
    logic                 id_ex_bubble;
    logic                 ex_mem_we;
    logic                 mem_wb_bubble;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    int testsRun;
    int testsFailed;

    pipeline_ctrl #(
        .REG_WIDTH (REG_WIDTH),
        .RESET_PC  (RESET_PC),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .dmem_busy     (dmem_busy),
        .imem_valid    (imem_valid),
        .halt_req      (halt_req),
        .pc            (pc),
        .pc_we         (pc_we),
        .if_id_we      (if_id_we),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_we     (ex_mem_we),
        .mem_wb_bubble (mem_wb_bubble),
        .halted        (halted),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        dmem_busy = 1'b0; imem_valid = 1'b1; halt_req = 1'b0;
        tick(); tick();
        testsRun++; if (pc !== 64'h1000) begin testsFailed++; $display("[TB] FAIL reset_pc: got %0h expected 1000", pc); end
        testsRun++; if ({pc_we, if_id_we, ex_mem_we} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_we: got %b expected 000", {pc_we, if_id_we, ex_mem_we}); end
        testsRun++; if ({if_id_flush, id_ex_bubble, mem_wb_bubble} !== 3'b111) begin testsFailed++; $display("[TB] FAIL reset_flush: got %b expected 111", {if_id_flush, id_ex_bubble, mem_wb_bubble}); end
        testsRun++; if ({halted, stall_cycles, flush_count} !== 9'd0) begin testsFailed++; $display("[TB] FAIL reset_cnt: got %b expected 0", {halted, stall_cycles, flush_count}); end
        rst_n = 1'b1;
        #1;
        testsRun++; if ({pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble} !== 6'b001111) begin
            testsFailed++; $display("[TB] FAIL boot_ctrl: got %b expected 001111", {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble});
        end
        tick();
        testsRun++; if (pc !== 64'h1000 || pc_we !== 1'b1 || if_id_we !== 1'b1) begin testsFailed++; $display("[TB] FAIL run_first: got pc=%0h we=%b expected pc=1000 we=1", pc, pc_we); end
        tick();
        testsRun++; if (pc !== 64'h1004) begin testsFailed++; $display("[TB] FAIL run_step1: got %0h expected 1004", pc); end
        tick();
        testsRun++; if (pc !== 64'h1008) begin testsFailed++; $display("[TB] FAIL run_step2: got %0h expected 1008", pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        testsRun++; if ({pc_we, if_id_we, id_ex_bubble, ex_mem_we} !== 4'b0011) begin testsFailed++; $display("[TB] FAIL stall_ctrl: got %b expected 0011", {pc_we, if_id_we, id_ex_bubble, ex_mem_we}); end
        tick();
        stall = 1'b0;
        testsRun++; if (pc !== 64'h1008 || stall_cycles !== 4'd1) begin testsFailed++; $display("[TB] FAIL stall_hold: got pc=%0h cnt=%0d expected pc=1008 cnt=1", pc, stall_cycles); end
        tick();
        testsRun++; if (pc !== 64'h100C) begin testsFailed++; $display("[TB] FAIL stall_resume: got %0h expected 100c", pc); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 64'h2000;
        #1;
        testsRun++; if ({pc_we, if_id_flush, id_ex_bubble} !== 3'b111) begin testsFailed++; $display("[TB] FAIL branch_ctrl: got %b expected 111", {pc_we, if_id_flush, id_ex_bubble}); end
        tick();
        branch_taken = 1'b0;
        testsRun++; if (pc !== 64'h2000 || flush_count !== 4'd1) begin testsFailed++; $display("[TB] FAIL branch_pc: got pc=%0h cnt=%0d expected pc=2000 cnt=1", pc, flush_count); end
    endtask

    task automatic test_freeze();
        dmem_busy = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h3000;
        #1;
        testsRun++; if ({pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble} !== 6'b000001) begin
            testsFailed++; $display("[TB] FAIL freeze_ctrl: got %b expected 000001", {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++; if (pc !== 64'h2000 || stall_cycles !== 4'd1 || flush_count !== 4'd1) begin
                testsFailed++; $display("[TB] FAIL freeze_hold%0d: got pc=%0h s=%0d f=%0d expected pc=2000 s=1 f=1", i, pc, stall_cycles, flush_count);
            end
        end
        dmem_busy = 1'b0;
        #1;
        testsRun++; if ({pc_we, if_id_flush, mem_wb_bubble, ex_mem_we} !== 4'b1101) begin testsFailed++; $display("[TB] FAIL freeze_release: got %b expected 1101", {pc_we, if_id_flush, mem_wb_bubble, ex_mem_we}); end
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        testsRun++; if (pc !== 64'h3000 || flush_count !== 4'd2 || stall_cycles !== 4'd1) begin
            testsFailed++; $display("[TB] FAIL freeze_branch: got pc=%0h s=%0d f=%0d expected pc=3000 s=1 f=2", pc, stall_cycles, flush_count);
        end
    endtask

    task automatic test_fetch_invalid();
        imem_valid = 1'b0;
        #1;
        testsRun++; if ({pc_we, if_id_we, if_id_flush} !== 3'b001) begin testsFailed++; $display("[TB] FAIL fetch_ctrl: got %b expected 001", {pc_we, if_id_we, if_id_flush}); end
        tick();
        imem_valid = 1'b1;
        testsRun++; if (pc !== 64'h3000) begin testsFailed++; $display("[TB] FAIL fetch_hold: got %0h expected 3000", pc); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        testsRun++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin testsFailed++; $display("[TB] FAIL wrap_top: got %0h expected fffffffffffffffc", pc); end
        tick();
        testsRun++; if (pc !== 64'h0 || flush_count !== 4'd3) begin testsFailed++; $display("[TB] FAIL wrap_zero: got pc=%0h f=%0d expected pc=0 f=3", pc, flush_count); end
    endtask

    task automatic test_saturate();
        stall = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        testsRun++; if (stall_cycles !== 4'd14) begin testsFailed++; $display("[TB] FAIL sat_below: got %0d expected 14", stall_cycles); end
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b0;
        testsRun++; if (stall_cycles !== 4'd15 || pc !== 64'h0) begin testsFailed++; $display("[TB] FAIL sat_hold: got cnt=%0d pc=%0h expected cnt=15 pc=0", stall_cycles, pc); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1; branch_taken = 1'b1; branch_target = 64'h5000;
        #1;
        testsRun++; if ({pc_we, if_id_flush, id_ex_bubble, ex_mem_we, halted} !== 5'b01110) begin
            testsFailed++; $display("[TB] FAIL halt_ctrl: got %b expected 01110", {pc_we, if_id_flush, id_ex_bubble, ex_mem_we, halted});
        end
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            testsRun++; if (halted !== 1'b1 || pc !== 64'h0 || pc_we !== 1'b0 || {if_id_flush, id_ex_bubble, mem_wb_bubble} !== 3'b111 || flush_count !== 4'd3) begin
                testsFailed++; $display("[TB] FAIL halt_hold%0d: got h=%b pc=%0h we=%b f=%0d expected h=1 pc=0 we=0 f=3", i, halted, pc, pc_we, flush_count);
            end
            tick();
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_reset_pulse();
        rst_n = 1'b0;
        #1;
        testsRun++; if (pc !== 64'h1000 || halted !== 1'b0 || stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            testsFailed++; $display("[TB] FAIL pulse_reset: got pc=%0h h=%b s=%0d f=%0d expected pc=1000 h=0 s=0 f=0", pc, halted, stall_cycles, flush_count);
        end
        rst_n = 1'b1;
        #1;
        testsRun++; if ({pc_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble} !== 5'b01111) begin
            testsFailed++; $display("[TB] FAIL pulse_boot: got %b expected 01111", {pc_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble});
        end
        tick();
        testsRun++; if (pc !== 64'h1000 || pc_we !== 1'b1) begin testsFailed++; $display("[TB] FAIL pulse_run: got pc=%0h we=%b expected pc=1000 we=1", pc, pc_we); end
        tick();
        testsRun++; if (pc !== 64'h1004) begin testsFailed++; $display("[TB] FAIL pulse_step: got %0h expected 1004", pc); end
    endtask

    // Run every scenario in order; each leaves the DUT where the next expects it.
    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_stall();
        test_branch();
        test_freeze();
        test_fetch_invalid();
        test_wrap();
        test_saturate();
        test_halt();
        test_reset_pulse();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
